// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the general-purpose register file. The
// datapath muxes and the hazard unit use the same definitions, so width, depth
// and the zero-register index are defined only here.
//
// Contents:
//   REGFILE_DW    - data width of one register, in bits
//   REGFILE_AW    - address width
//   REGFILE_DEPTH - number of registers (2**REGFILE_AW)
//   REG_ZERO      - index of the hard-wired zero register
//   reg_addr_t    - register address type
//   reg_data_t    - register data type
//   is_zero_reg() - returns 1 when an address selects the zero register
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int unsigned REGFILE_DW    = 32;
    localparam int unsigned REGFILE_AW    = 5;
    localparam int unsigned REGFILE_DEPTH = 2 ** REGFILE_AW;
    localparam int unsigned REG_ZERO      = 0;

    typedef logic [REGFILE_AW-1:0] reg_addr_t;
    typedef logic [REGFILE_DW-1:0] reg_data_t;

    // Zero-register test for use by decode/hazard logic at the default width
    function automatic logic is_zero_reg(input reg_addr_t addr);
        return (addr == reg_addr_t'(REG_ZERO));
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// -----------------------------------------------------------------------------
// regfile_rdport
// One combinational read port of the register file. Register 0 always reads
// zero. When REGFILE_BYPASS_EN is defined, a write in flight to the same
// address is forwarded to the output in the same cycle; without the macro the
// forwarding ports and logic do not exist.
//
// Ports:
//   fwd_we_i  - write enable to forward (REGFILE_BYPASS_EN only; already
//               masked by reset in the parent)
//   fwd_wa_i  - write address to compare against (REGFILE_BYPASS_EN only)
//   fwd_wd_i  - write data to forward (REGFILE_BYPASS_EN only)
//   regs_i    - current register contents
//   ra_i      - read address
//   rd_o      - read data (combinational)
// -----------------------------------------------------------------------------
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int unsigned DW = REGFILE_DW,
    parameter int unsigned AW = REGFILE_AW
) (
`ifdef REGFILE_BYPASS_EN
    input  logic          fwd_we_i,
    input  logic [AW-1:0] fwd_wa_i,
    input  logic [DW-1:0] fwd_wd_i,
`endif
    input  logic [DW-1:0] regs_i [2**AW],
    input  logic [AW-1:0] ra_i,
    output logic [DW-1:0] rd_o
);

    // Read mux: zero register first, then optional forwarding, then storage
    always_comb begin
        rd_o = '0;
        if (ra_i == AW'(REG_ZERO)) begin
            rd_o = '0;
        end
`ifdef REGFILE_BYPASS_EN
        // ra_i is nonzero here, so a match also implies the write is not to
        // the zero register.
        else if (fwd_we_i && (fwd_wa_i == ra_i)) begin
            rd_o = fwd_wd_i;
        end
`endif
        else begin
            rd_o = regs_i[ra_i];
        end
    end

endmodule

// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile
// 2**AW x DW register file with one synchronous write port and two
// independent combinational read ports. Register 0 is hard-wired to zero and
// writes to it are dropped. Asynchronous active-high reset clears every
// register immediately.
//
// Configuration macro:
//   REGFILE_BYPASS_EN - when defined, a write (we=1, wa!=0) is forwarded to any
//                       read port whose address matches wa in the same cycle.
//                       Forwarding is suppressed while rst is high so reads
//                       stay zero during reset.
//
// Ports:
//   clk - clock, all state updates on the rising edge
//   rst - asynchronous active-high reset
//   we  - write enable
//   wa  - write address
//   wd  - write data
//   ra1 - read address, port 1 (rs)
//   rd1 - read data, port 1
//   ra2 - read address, port 2 (rt)
//   rd2 - read data, port 2
// -----------------------------------------------------------------------------
module regfile
    import regfile_pkg::*;
#(
    parameter int unsigned DW = REGFILE_DW,
    parameter int unsigned AW = REGFILE_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra1,
    output logic [DW-1:0] rd1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd2
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] regs_q [DEPTH];
    logic [DW-1:0] regs_d [DEPTH];

    // Next-state: apply the single write, keep the zero register at zero.
    // The address is only evaluated when we=1, so an unknown wa with we=0
    // cannot disturb any entry.
    always_comb begin
        regs_d = regs_q;
        if (we && (wa != AW'(REG_ZERO))) begin
            regs_d[wa] = wd;
        end else begin
            regs_d = regs_q;
        end
        regs_d[REG_ZERO] = '0;
    end

    // Register storage with asynchronous clear; reset wins over a write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_we_s;

    // Forward only outside reset so all reads stay zero while rst is high
    assign fwd_we_s = we & ~rst;
`endif

    regfile_rdport #(
        .DW (DW),
        .AW (AW)
    ) u_rdport1 (
`ifdef REGFILE_BYPASS_EN
        .fwd_we_i (fwd_we_s),
        .fwd_wa_i (wa),
        .fwd_wd_i (wd),
`endif
        .regs_i   (regs_q),
        .ra_i     (ra1),
        .rd_o     (rd1)
    );

    regfile_rdport #(
        .DW (DW),
        .AW (AW)
    ) u_rdport2 (
`ifdef REGFILE_BYPASS_EN
        .fwd_we_i (fwd_we_s),
        .fwd_wa_i (wa),
        .fwd_wd_i (wd),
`endif
        .regs_i   (regs_q),
        .ra_i     (ra2),
        .rd_o     (rd2)
    );

endmodule

// File: tb/tb_regfile.sv
// -----------------------------------------------------------------------------
// tb_regfile
// Self-checking bench for regfile: a vector table, hand-written corner-case
// sequences (same-cycle hazard, zero register, unknown address, async reset
// mid-write, full sweep) and a randomized phase against a reference model.
// -----------------------------------------------------------------------------
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [31:0] rd1;
    logic [4:0]  ra2;
    logic [31:0] rd2;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain array of register values; entry 0 is never written
    logic [31:0] model [32];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [8];

    regfile dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .wa  (wa),
        .wd  (wd),
        .ra1 (ra1),
        .rd1 (rd1),
        .ra2 (ra2),
        .rd2 (rd2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected combinational read value given the current bench inputs
    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (rst === 1'b1) return 32'h0;
        if (ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we === 1'b1 && wa == ra) return wd;
`endif
        return model[ra];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Advance one rising edge, updating the model first, then settle past it
    task automatic tick();
        if (rst !== 1'b1 && we === 1'b1 && wa !== 5'd0) model[wa] = wd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] expv;

        clear_model();
        we  = 1'b0; wa = 5'd0; wd = 32'h0; ra1 = 5'd0; ra2 = 5'd0;
        rst = 1'b1;
        #1;
        ra1 = 5'd9; ra2 = 5'd30;
        #1;
        check("reset_rd1", rd1, 32'h0);
        check("reset_rd2", rd2, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // ---------------- table-driven vectors (values checked after edge)
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h00000000, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 5'd5,  32'h12345678, 5'd5,  5'd0,  32'hDEADBEEF, 32'h00000000};
        vecs[3] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd5,  32'hA5A5A5A5, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 5'd1,  32'h00000001, 5'd1,  5'd31, 32'h00000001, 32'hA5A5A5A5};
        vecs[5] = '{1'b1, 5'd5,  32'hCAFEF00D, 5'd1,  5'd5,  32'h00000001, 32'hCAFEF00D};
        vecs[6] = '{1'b0, 5'd31, 32'h00000000, 5'd31, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[7] = '{1'b1, 5'd7,  32'h00000011, 5'd7,  5'd5,  32'h00000011, 32'hCAFEF00D};
        for (int v = 0; v < 8; v++) begin
            we = vecs[v].we; wa = vecs[v].wa; wd = vecs[v].wd;
            ra1 = vecs[v].ra1; ra2 = vecs[v].ra2;
            tick();
            check($sformatf("vec%0d_rd1", v), rd1, vecs[v].exp1);
            check($sformatf("vec%0d_rd2", v), rd2, vecs[v].exp2);
        end

        // ---------------- same-cycle hazard on reg 7 (holds 0x11)
        we = 1'b1; wa = 5'd7; wd = 32'h22; ra1 = 5'd7; ra2 = 5'd1;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("hazard_pre", rd1, 32'h22);
`else
        check("hazard_pre", rd1, 32'h11);
`endif
        check("hazard_pre_rd2", rd2, 32'h1);
        tick();
        we = 1'b0;
        #1;
        check("hazard_post", rd1, 32'h22);

        // ---------------- zero register write attempt
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0;
        #1;
        check("zero_pre_rd1", rd1, 32'h0);
        check("zero_pre_rd2", rd2, 32'h0);
        tick();
        check("zero_post_rd1", rd1, 32'h0);

        // ---------------- unknown write address with we=0
        we = 1'b0; wa = 5'bxxxxx; wd = 32'h5A5A5A5A; ra1 = 5'd5; ra2 = 5'd7;
        tick();
        wa = 5'd0;
        #1;
        check("xwa_reg5", rd1, 32'hCAFEF00D);
        check("xwa_reg7", rd2, 32'h22);

        // ---------------- sweep: write i*0x01010101, then read all pairs
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = 32'(i) * 32'h01010101;
            tick();
        end
        we = 1'b0; wa = 5'd0;
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                ra1 = 5'(a); ra2 = 5'(b);
                #1;
                check($sformatf("sweep_rd1_%0d", a), rd1, 32'(a) * 32'h01010101);
                check($sformatf("sweep_rd2_%0d", b), rd2, 32'(b) * 32'h01010101);
            end
        end

        // ---------------- async reset mid-write, contents all nonzero
        @(negedge clk);
        we = 1'b1; wa = 5'd3; wd = 32'h44; ra1 = 5'd3; ra2 = 5'd5;
        #1;
        check("prereset_rd2", rd2, 32'h05050505);
        rst = 1'b1;
        #1;
        check("rstmid_rd1", rd1, 32'h0);
        check("rstmid_rd2", rd2, 32'h0);
        clear_model();
        tick();
        check("rstedge_rd1", rd1, 32'h0);
        we = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a); ra2 = 5'(31 - a);
            #1;
            check($sformatf("rstall_rd1_%0d", a), rd1, 32'h0);
            check($sformatf("rstall_rd2_%0d", a), rd2, 32'h0);
        end
        rst = 1'b0;

        // ---------------- first write after reset release
        we = 1'b1; wa = 5'd3; wd = 32'h55; ra1 = 5'd3; ra2 = 5'd4;
        tick();
        we = 1'b0;
        #1;
        check("postrst_write", rd1, 32'h55);
        check("postrst_other", rd2, 32'h0);

        // ---------------- randomized phase against the model
        for (int c = 0; c < 400; c++) begin
            we  = ($urandom_range(0, 3) != 0);
            wa  = 5'($urandom_range(0, 31));
            wd  = $urandom();
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 7) == 0) ? ra1 : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                #1;
                clear_model();
            end else begin
                #1;
            end
            expv = exp_rd(ra1);
            check("rand_rd1", rd1, expv);
            expv = exp_rd(ra2);
            check("rand_rd2", rd2, expv);
            tick();
            rst = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter DW, default 32: data width of each register, in bits.
REQ-002 Parameter AW, default 5: address width; the register count SHALL be 2**AW.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on the rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port we, input, 1: write enable for the write port.
REQ-006 Port wa, input, AW: write address (the register selected by the writeback-destination mux).
REQ-007 Port wd, input, DW: write data.
REQ-008 Port ra1, input, AW: read address for port 1 (rs).
REQ-009 Port rd1, output, DW: read data for port 1.
REQ-010 Port ra2, input, AW: read address for port 2 (rt).
REQ-011 Port rd2, output, DW: read data for port 2.

Function
REQ-012 Reads SHALL be combinational with zero latency: rdN reflects the current contents of register raN in the same cycle.
REQ-013 Register 0 SHALL always read 0; writes to address 0 SHALL be discarded.
REQ-014 A write SHALL occur at the rising clk edge when we=1 and wa!=0; the new value SHALL be visible on reads from the cycle after that edge.
REQ-015 When we=0, no register SHALL change.
REQ-016 Both read ports SHALL be independent; ra1==ra2 SHALL return identical data on both ports.
REQ-017 Read-during-write to the same address (bypass disabled): rdN SHALL show the old value until the edge, then the new value.
REQ-018 X or Z on wa while we=0 SHALL NOT corrupt any register.
REQ-019 Only one write port exists; there SHALL be no write arbitration.

Reset
REQ-020 While rst=1, all registers SHALL be 0 immediately, regardless of clk.
REQ-021 If rst and a write edge coincide, reset SHALL win and the write SHALL be lost.
REQ-022 After rst is deasserted, the first write SHALL be accepted on the next rising edge.
REQ-023 During reset, rd1 and rd2 SHALL read 0 for every address.

Configuration
REQ-024 Macro REGFILE_BYPASS_EN: when defined, if we=1, wa!=0 and raN==wa, rdN SHALL return wd combinationally in the same cycle (write-to-read forwarding).
REQ-025 When REGFILE_BYPASS_EN is defined, address 0 SHALL still read 0 even if wa=0 and we=1.
REQ-026 When REGFILE_BYPASS_EN is undefined, behaviour SHALL follow REQ-017 exactly, with no bypass logic synthesized.

Structure
REQ-027 A shared package SHALL hold the constants for register-file width and depth and the named index of the zero register, for reuse by the datapath muxes and the hazard unit.
REQ-028 The module SHALL be flat; it SHALL contain at most one sub-module, regfile_rdport, which implements one read port plus its optional bypass and is instantiated twice.

Verification
REQ-029 Reset: assert rst with prior contents nonzero -> all 32 registers read 0 on both ports immediately; no clock edge is needed.
REQ-030 Write/read: we=1, wa=5, wd=0xDEADBEEF at one edge, then ra1=5, ra2=5 -> rd1=rd2=0xDEADBEEF from the next cycle.
REQ-031 Zero register: we=1, wa=0, wd=0xFFFFFFFF -> ra1=0 reads 0 before and after the edge.
REQ-032 Same-cycle hazard: reg 7 holds 0x11; drive we=1, wa=7, wd=0x22, ra1=7 -> before the edge rd1 reads 0x22 with REGFILE_BYPASS_EN defined and 0x11 without it; after the edge it reads 0x22 in both builds.
REQ-033 Async reset mid-write: rst rises between edges while we=1, wa=3 -> reg 3 reads 0 and stays 0 through the next edge while rst=1.
REQ-034 Sweep: write address i with value i*0x01010101 for i=1..31, then read all pairs -> every read matches its written value and reg 0 reads 0.
